// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one 1-bit slice iterated LSB-first over WIDTH bits with a carry flop.
// Optional build macro ALU_SERIAL_OVF_EN enables the registered signed-overflow output.
module alu_serial_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, acc_q, result_q;
  logic [2:0]       op_q;
  logic             carry_q, zero_q, cout_q;
  logic [CntW-1:0]  cnt_q;

  logic             accept, last;
  logic             bb, g, p, sum, carry_nxt, bit_res, ovf_int;
  logic [WIDTH-1:0] final_res;

  assign accept = (state_q == StIdle) && start;
  assign last   = (cnt_q == CntW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: if (start) state_d = StRun;
      StRun: begin
        busy = 1'b1;
        if (last) state_d = StDone;
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // One-bit slice operating on the current LSB of the operand shift registers.
  always_comb begin
    bb        = b_q[0] ^ op_q[2];
    g         = a_q[0] & bb;
    p         = a_q[0] | bb;
    sum       = a_q[0] ^ bb ^ carry_q;
    carry_nxt = g | (p & carry_q);
    ovf_int   = carry_q ^ carry_nxt;
    unique case (op_q[1:0])
      2'b00:   bit_res = g;
      2'b01:   bit_res = p;
      2'b10:   bit_res = sum;
      default: bit_res = 1'b0;
    endcase
    // SLT replaces the shifted result with the overflow-corrected sign bit.
    if (op_q[1:0] == 2'b11) final_res = WIDTH'(sum ^ ovf_int);
    else                    final_res = {bit_res, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      cout_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      op_q    <= op;
      carry_q <= op[2];
      cnt_q   <= '0;
    end else if (state_q == StRun) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      carry_q <= carry_nxt;
      cnt_q   <= cnt_q + CntW'(1);
      acc_q   <= {bit_res, acc_q[WIDTH-1:1]};
      if (last) begin
        result_q <= final_res;
        zero_q   <= (final_res == '0);
        cout_q   <= op_q[1] & carry_nxt;
      end
    end
  end

`ifdef ALU_SERIAL_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if ((state_q == StRun) && last) begin
      ovf_q <= op_q[1] & ovf_int;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign result = result_q;
  assign zero   = zero_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq (WIDTH=32): ops, latency, handshake and mid-run reset.
module tb_alu_serial_seq;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   op = '0;
  logic         busy, done, zero, cout, overflow;
  logic [W-1:0] result;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] last_exp = '0;

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .op(op),
    .busy(busy), .done(done), .result(result), .zero(zero), .cout(cout),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic [2:0] top, input logic [W-1:0] e_res,
                        input logic e_cout, input logic e_ovf);
    int lat;
    logic e_ov;
`ifdef ALU_SERIAL_OVF_EN
    e_ov = e_ovf;
`else
    e_ov = 1'b0;
`endif
    @(negedge clk);
    a = ta; b = tb_; op = top; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~ta; b = ~tb_; op = ~top;  // captured operands must be used
    lat = 1;
    chk({tag, " busy"}, W'(busy), W'(1'b1));
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 20) chk({tag, " result held"}, result, last_exp);
    end
    chk({tag, " done"}, W'(done), W'(1'b1));
    chk({tag, " latency"}, W'(lat), W'(W + 1));
    chk({tag, " result"}, result, e_res);
    chk({tag, " zero"}, W'(zero), W'(e_res == '0));
    chk({tag, " cout"}, W'(cout), W'(e_cout));
    chk({tag, " overflow"}, W'(overflow), W'(e_ov));
    last_exp = e_res;
    @(posedge clk); #1;
    chk({tag, " done pulse"}, W'(done), W'(1'b0));
    chk({tag, " idle"}, W'(busy), W'(1'b0));
  endtask

  initial begin
    int lat;
    int ndone;

    #12;
    chk("rst busy", W'(busy), W'(1'b0));
    chk("rst done", W'(done), W'(1'b0));
    chk("rst result", result, '0);
    chk("rst zero", W'(zero), W'(1'b1));
    chk("rst cout", W'(cout), W'(1'b0));
    chk("rst overflow", W'(overflow), W'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add", 32'h0000_0005, 32'h0000_0003, 3'b010, 32'h0000_0008, 1'b0, 1'b0);
    run_op("sub", 32'h1234_5678, 32'h1234_5678, 3'b110, 32'h0000_0000, 1'b1, 1'b0);
    run_op("slt ovf", 32'h8000_0000, 32'h0000_0001, 3'b111, 32'h0000_0001, 1'b1, 1'b1);
    run_op("slt neg", 32'h0000_0005, 32'hFFFF_FFFD, 3'b111, 32'h0000_0000, 1'b0, 1'b0);
    run_op("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000, 32'hF000_F000, 1'b0, 1'b0);
    run_op("or", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b001, 32'hFFF0_FFF0, 1'b0, 1'b0);
    run_op("andn", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 32'h00F0_00F0, 1'b0, 1'b0);
    run_op("add ovf", 32'h7FFF_FFFF, 32'h0000_0001, 3'b010, 32'h8000_0000, 1'b0, 1'b1);

    // Start re-asserted during RUN and held through DONE is ignored.
    @(negedge clk);
    a = 32'd1; b = 32'd1; op = 3'b010; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    ndone = 0;
    while (lat < 40) begin
      if (lat == 5) begin
        start = 1'b1; a = 32'd100; b = 32'd100;
      end
      @(posedge clk); #1;
      lat++;
      if (done) begin
        ndone++;
        break;
      end
    end
    chk("hs latency", W'(lat), W'(W + 1));
    chk("hs result", result, 32'd2);
    @(posedge clk); #1;
    chk("hs start in done ignored", W'(busy), W'(1'b0));
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("hs idle after", W'(busy), W'(1'b0));
    chk("hs one done", W'(ndone), W'(1));
    last_exp = 32'd2;

    // Reset in the middle of RUN aborts the operation.
    @(negedge clk);
    a = 32'd9; b = 32'd9; op = 3'b010; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid rst busy", W'(busy), W'(1'b0));
    chk("mid rst done", W'(done), W'(1'b0));
    chk("mid rst result", result, '0);
    chk("mid rst zero", W'(zero), W'(1'b1));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    chk("mid rst no done", W'(ndone), W'(0));
    last_exp = '0;
    run_op("post rst add", 32'h0000_0010, 32'h0000_0020, 3'b010, 32'h0000_0030, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
